// File: rtl/rc4_phase_ctrl.sv
// Top-level RC4 sequencer: runs S-init, KSA and PRGA phases in order and owns the S-memory port.
// Optional key-search retry loop is enabled with `define RC4_KEY_SEARCH_EN.
module rc4_phase_ctrl #(
    parameter int                KEY_W   = 24,
    parameter logic [KEY_W-1:0]  KEY_MAX = KEY_W'(24'h3FFFFF),
    parameter int                MEM_AW  = 8,
    parameter int                DW      = 8,
    parameter int                WDOG_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [KEY_W-1:0]  key_in,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_done,
    input  logic              ksa_done,
    input  logic              prga_done,
    input  logic              prga_fail,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [DW-1:0]     init_wdata,
    input  logic              init_wren,
    input  logic [MEM_AW-1:0] ksa_addr,
    input  logic [DW-1:0]     ksa_wdata,
    input  logic              ksa_wren,
    input  logic [MEM_AW-1:0] prga_addr,
    input  logic [DW-1:0]     prga_wdata,
    input  logic              prga_wren,
    output logic [MEM_AW-1:0] s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic              s_wren,
    output logic [KEY_W-1:0]  key_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              timeout
);

    typedef enum logic [3:0] {
        IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE, FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   key_reg;
    logic [WDOG_W-1:0]  wdog;
    logic               key_load, key_inc, wdog_clr, wdog_inc, to_set;
    logic               wdog_exp;

    assign wdog_exp = (wdog == {WDOG_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_reg <= '0;
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (key_load)
                key_reg <= key_in;
            else if (key_inc)
                key_reg <= key_reg + KEY_W'(1);
            if (wdog_clr)
                wdog <= '0;
            else if (wdog_inc)
                wdog <= wdog + WDOG_W'(1);
            if (key_load)
                timeout <= 1'b0;
            else if (to_set)
                timeout <= 1'b1;
        end
    end

    // Next-state: a phase's done wins over watchdog expiry in the same cycle
    always_comb begin
        state_nxt = state;
        key_load  = 1'b0;
        key_inc   = 1'b0;
        wdog_clr  = 1'b0;
        wdog_inc  = 1'b0;
        to_set    = 1'b0;
        case (state)
            IDLE, DONE, FAIL: begin
                if (go) begin
                    key_load  = 1'b1;
                    state_nxt = INIT_GO;
                end
            end
            INIT_GO: begin
                wdog_clr  = 1'b1;
                state_nxt = INIT_WAIT;
            end
            KSA_GO: begin
                wdog_clr  = 1'b1;
                state_nxt = KSA_WAIT;
            end
            PRGA_GO: begin
                wdog_clr  = 1'b1;
                state_nxt = PRGA_WAIT;
            end
            INIT_WAIT: begin
                wdog_inc = 1'b1;
                if (init_done)
                    state_nxt = KSA_GO;
                else if (wdog_exp) begin
                    state_nxt = FAIL;
                    to_set    = 1'b1;
                end
            end
            KSA_WAIT: begin
                wdog_inc = 1'b1;
                if (ksa_done)
                    state_nxt = PRGA_GO;
                else if (wdog_exp) begin
                    state_nxt = FAIL;
                    to_set    = 1'b1;
                end
            end
            PRGA_WAIT: begin
                wdog_inc = 1'b1;
                if (prga_done) begin
                    if (!prga_fail)
                        state_nxt = DONE;
                    else begin
`ifdef RC4_KEY_SEARCH_EN
                        if (key_reg != KEY_MAX) begin
                            key_inc   = 1'b1;
                            state_nxt = INIT_GO;
                        end else
                            state_nxt = FAIL;
`else
                        state_nxt = FAIL;
`endif
                    end
                end else if (wdog_exp) begin
                    state_nxt = FAIL;
                    to_set    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // S-memory ownership: only the active phase reaches the RAM
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        case (state)
            INIT_GO, INIT_WAIT: begin
                s_addr  = init_addr;
                s_wdata = init_wdata;
                s_wren  = init_wren;
            end
            KSA_GO, KSA_WAIT: begin
                s_addr  = ksa_addr;
                s_wdata = ksa_wdata;
                s_wren  = ksa_wren;
            end
            PRGA_GO, PRGA_WAIT: begin
                s_addr  = prga_addr;
                s_wdata = prga_wdata;
                s_wren  = prga_wren;
            end
            default: ;
        endcase
    end

    assign init_start = (state == INIT_GO);
    assign ksa_start  = (state == KSA_GO);
    assign prga_start = (state == PRGA_GO);
    assign busy       = (state != IDLE) && (state != DONE) && (state != FAIL);
    assign done       = (state == DONE);
    assign fail       = (state == FAIL);
    assign key_out    = key_reg;

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: two instances (default watchdog, and WDOG_W=4 / KEY_MAX=3) against a phase-level model.
`timescale 1ns/1ps
module tb_rc4_phase_ctrl;

`ifdef RC4_KEY_SEARCH_EN
    localparam bit SEARCH = 1'b1;
`else
    localparam bit SEARCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] init_addr = 0, init_wdata = 0, ksa_addr = 0, ksa_wdata = 0, prga_addr = 0, prga_wdata = 0;
    logic init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b0;

    logic go_a = 0, init_done_a = 0, ksa_done_a = 0, prga_done_a = 0, prga_fail_a = 0;
    logic go_b = 0, init_done_b = 0, ksa_done_b = 0, prga_done_b = 0, prga_fail_b = 0;
    logic [23:0] key_in_a = 0, key_in_b = 0;
    logic init_start_a, ksa_start_a, prga_start_a, busy_a, done_a, fail_a, timeout_a, s_wren_a;
    logic init_start_b, ksa_start_b, prga_start_b, busy_b, done_b, fail_b, timeout_b, s_wren_b;
    logic [7:0]  s_addr_a, s_wdata_a, s_addr_b, s_wdata_b;
    logic [23:0] key_out_a, key_out_b;

    rc4_phase_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .key_in(key_in_a),
        .init_start(init_start_a), .ksa_start(ksa_start_a), .prga_start(prga_start_a),
        .init_done(init_done_a), .ksa_done(ksa_done_a), .prga_done(prga_done_a), .prga_fail(prga_fail_a),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wdata(prga_wdata), .prga_wren(prga_wren),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .key_out(key_out_a),
        .busy(busy_a), .done(done_a), .fail(fail_a), .timeout(timeout_a));

    rc4_phase_ctrl #(.KEY_MAX(24'd3), .WDOG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .key_in(key_in_b),
        .init_start(init_start_b), .ksa_start(ksa_start_b), .prga_start(prga_start_b),
        .init_done(init_done_b), .ksa_done(ksa_done_b), .prga_done(prga_done_b), .prga_fail(prga_fail_b),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wdata(prga_wdata), .prga_wren(prga_wren),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .key_out(key_out_b),
        .busy(busy_b), .done(done_b), .fail(fail_b), .timeout(timeout_b));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // Phase-level model: ph 0 = not running, 1..3 = init/ksa/prga; st = start cycle of that phase
    typedef struct {
        int          ph;
        bit          st;
        int          cnt;
        bit          dn, fl, to;
        logic [23:0] key;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, bit g, logic [23:0] kin, bit d1, bit d2, bit d3,
                                  bit pf, int wmax, logic [23:0] kmax);
        mdl_t n;
        bit d;
        n = m;
        if (m.ph == 0) begin
            if (g) begin
                n.key = kin; n.to = 0; n.dn = 0; n.fl = 0; n.ph = 1; n.st = 1;
            end
        end else if (m.st) begin
            n.st = 0; n.cnt = 0;
        end else begin
            d = (m.ph == 1) ? d1 : (m.ph == 2) ? d2 : d3;
            if (d) begin
                if (m.ph < 3) begin n.ph = m.ph + 1; n.st = 1; end
                else if (!pf) begin n.ph = 0; n.dn = 1; end
                else if (SEARCH && m.key != kmax) begin n.key = m.key + 24'd1; n.ph = 1; n.st = 1; end
                else begin n.ph = 0; n.fl = 1; end
            end else if (m.cnt == wmax) begin
                n.ph = 0; n.fl = 1; n.to = 1;
            end else n.cnt = m.cnt + 1;
        end
        return n;
    endfunction

    function automatic logic [47:0] expv(mdl_t m);
        logic [7:0] a, w;
        logic we;
        a = 0; w = 0; we = 0;
        case (m.ph)
            1: begin a = init_addr; w = init_wdata; we = init_wren; end
            2: begin a = ksa_addr;  w = ksa_wdata;  we = ksa_wren;  end
            3: begin a = prga_addr; w = prga_wdata; we = prga_wren; end
            default: ;
        endcase
        return {m.ph != 0, m.dn, m.fl, m.to, m.st && m.ph == 1, m.st && m.ph == 2, m.st && m.ph == 3,
                m.key, a, w, we};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = step(ma, go_a, key_in_a, init_done_a, ksa_done_a, prga_done_a, prga_fail_a, 65535, 24'h3FFFFF);
            mb = step(mb, go_b, key_in_b, init_done_b, ksa_done_b, prga_done_b, prga_fail_b, 15, 24'd3);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cycle_a", {busy_a, done_a, fail_a, timeout_a, init_start_a, ksa_start_a, prga_start_a,
                            key_out_a, s_addr_a, s_wdata_a, s_wren_a}, expv(ma));
            chk("cycle_b", {busy_b, done_b, fail_b, timeout_b, init_start_b, ksa_start_b, prga_start_b,
                            key_out_b, s_addr_b, s_wdata_b, s_wren_b}, expv(mb));
        end
    end

    // Memory request stimulus changes every cycle; init/ksa write enables stay high
    initial begin
        forever begin
            @(posedge clk); #1;
            init_addr = 8'($urandom); init_wdata = 8'($urandom);
            ksa_addr  = 8'($urandom); ksa_wdata  = 8'($urandom);
            prga_addr = 8'($urandom); prga_wdata = 8'($urandom);
            prga_wren = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic bit start_of(bit b, int which);
        if (b) return (which == 1) ? init_start_b : (which == 2) ? ksa_start_b : prga_start_b;
        return (which == 1) ? init_start_a : (which == 2) ? ksa_start_a : prga_start_a;
    endfunction

    task automatic set_done(input bit b, input int which, input bit v, input bit pf);
        if (b) begin
            init_done_b = (which == 1) && v; ksa_done_b = (which == 2) && v;
            prga_done_b = (which == 3) && v; prga_fail_b = pf;
        end else begin
            init_done_a = (which == 1) && v; ksa_done_a = (which == 2) && v;
            prga_done_a = (which == 3) && v; prga_fail_a = pf;
        end
    endtask

    task automatic pulse_done(input bit b, input int which, input bit pf);
        set_done(b, which, 1'b1, pf);
        tick();
        set_done(b, which, 1'b0, 1'b0);
    endtask

    task automatic pulse_go(input bit b, input logic [23:0] k);
        if (b) begin go_b = 1; key_in_b = k; end else begin go_a = 1; key_in_a = k; end
        tick();
        go_a = 0; go_b = 0;
    endtask

    task automatic wait_start(input bit b, input int which, output int cyc);
        cyc = 0;
        while (!start_of(b, which) && cyc < 100) begin tick(); cyc++; end
        chk($sformatf("start%0d_seen", which), 64'(start_of(b, which)), 64'd1);
    endtask

    task automatic run_phase(input bit b, input int which, input int lat, input bit pf);
        int c;
        wait_start(b, which, c);
        ticks(lat);
        pulse_done(b, which, pf);
    endtask

    int c, n, inits;

    initial begin
        #2;
        chk("reset_outputs_a", {busy_a, done_a, fail_a, timeout_a, init_start_a, ksa_start_a, prga_start_a,
                                key_out_a, s_wren_a}, 64'd0);
        ticks(3);
        rst_n = 1;
        tick();

        // Nominal run with stray/ignored events
        pulse_go(0, 24'h000249);
        chk("go_to_init_start", 64'(init_start_a), 64'd1);
        tick();
        chk("init_start_one_cycle", 64'(init_start_a), 64'd0);
        ticks(5);
        ksa_done_a = 1; tick(); ksa_done_a = 0;
        chk("stray_ksa_done_ignored", {busy_a, ksa_start_a}, 64'b10);
        ticks(249);
        pulse_done(0, 1, 0);
        chk("init_done_to_ksa_start", 64'(ksa_start_a), 64'd1);
        ticks(11);
        chk("ksa_owner_wren", 64'(s_wren_a), 64'd1);
        go_a = 1; key_in_a = 24'hABCDEF; tick(); go_a = 0;
        ticks(756);
        chk("go_in_ksa_ignored_key", 64'(key_out_a), 64'h000249);
        pulse_done(0, 2, 0);
        chk("ksa_done_to_prga_start", 64'(prga_start_a), 64'd1);
        ticks(6);
        prga_fail_a = 1; tick(); prga_fail_a = 0;
        chk("lone_prga_fail_ignored", {busy_a, fail_a}, 64'b10);
        ticks(24);
        pulse_done(0, 3, 0);
        chk("nominal_done", {done_a, busy_a, fail_a, s_wren_a}, 64'b1000);
        chk("nominal_key_out", 64'(key_out_a), 64'h000249);

`ifndef RC4_KEY_SEARCH_EN
        // PRGA failure without key search
        pulse_go(0, 24'h000005);
        run_phase(0, 1, 3, 0);
        run_phase(0, 2, 3, 0);
        run_phase(0, 3, 3, 1);
        chk("prga_fail_result", {fail_a, timeout_a, done_a, busy_a}, 64'b1000);
        chk("prga_fail_key_kept", 64'(key_out_a), 64'h000005);
`endif

        // Watchdog expiry in KSA_WAIT (4-bit watchdog)
        pulse_go(1, 24'h0000AA);
        run_phase(1, 1, 3, 0);
        n = 0;
        while (!fail_b && n < 40) begin tick(); n++; end
        chk("wdog_cycles_to_fail", 64'(n), 64'd17);
        chk("wdog_flags", {fail_b, timeout_b, busy_b, done_b}, 64'b1100);

        // Done coinciding with watchdog expiry wins
        pulse_go(1, 24'h0000AB);
        chk("go_clears_timeout", 64'(timeout_b), 64'd0);
        run_phase(1, 1, 3, 0);
        ticks(16);
        pulse_done(1, 2, 0);
        chk("done_beats_wdog", {prga_start_b, fail_b, timeout_b}, 64'b100);
        ticks(4);
        pulse_done(1, 3, 0);
        chk("done_after_near_expiry", 64'(done_b), 64'd1);

`ifdef RC4_KEY_SEARCH_EN
        // Key search: keys 0..2 fail, key 3 passes
        pulse_go(1, 24'd0);
        inits = 0;
        for (int k = 0; k < 4; k++) begin
            if (start_of(1, 1)) inits++;
            run_phase(1, 1, 2, 0);
            run_phase(1, 2, 2, 0);
            run_phase(1, 3, 2, k < 3);
        end
        chk("search_init_count", 64'(inits), 64'd4);
        chk("search_pass", {done_b, fail_b, busy_b}, 64'b100);
        chk("search_pass_key", 64'(key_out_b), 64'd3);
        // Key search: every key fails
        pulse_go(1, 24'd0);
        for (int k = 0; k < 4; k++) begin
            run_phase(1, 1, 2, 0);
            run_phase(1, 2, 2, 0);
            run_phase(1, 3, 2, 1);
        end
        chk("search_exhausted", {fail_b, timeout_b, done_b}, 64'b100);
        chk("search_exhausted_key", 64'(key_out_b), 64'd3);
`endif

        // Asynchronous reset in PRGA_WAIT
        pulse_go(0, 24'h000077);
        run_phase(0, 1, 2, 0);
        run_phase(0, 2, 2, 0);
        wait_start(0, 3, c);
        ticks(5);
        chk("pre_reset_busy", 64'(busy_a), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_a", {busy_a, done_a, fail_a, timeout_a, init_start_a, ksa_start_a, prga_start_a,
                              key_out_a, s_addr_a, s_wdata_a, s_wren_a}, 64'd0);
        chk("async_reset_b", {busy_b, done_b, fail_b, timeout_b, key_out_b, s_wren_b}, 64'd0);
        ticks(2);
        rst_n = 1;
        tick();
        pulse_go(0, 24'h000012);
        chk("restart_after_reset", {init_start_a, busy_a}, 64'b11);
        ticks(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
